gpu_fb_writer: RTL and testbench

- Downstream consumer of the gpu pixel stream: samples x/y/r/g/b whenever data_avail is high.
- Clips each pixel to the framebuffer, computes a linear framebuffer address and packs RGB into one word.
- Buffers the result in a FIFO and drains it to the framebuffer SRAM controller over a req/ack handshake.
- Decouples the gpu's one-pixel-per-cycle bursts from SRAM write latency.

---
 rtl/gpu_fb_writer.sv | 157 +++++++++++++++
 tb/tb_gpu_fb_writer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/gpu_fb_writer.sv
// Clips, addresses and packs gpu pixels, queues them, and writes them to framebuffer SRAM over req/ack.
// Latency: sample at edge N, sram_req_o high from edge N+1; one write per cycle with ack held high.
// Backpressure: none upstream; pixels arriving at a full FIFO are dropped (sticky overflow_o). Macro GPU_FB_DROP_CNT_EN adds drop_count_o.

module gpu_fb_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
endmodule

module gpu_fb_writer #(
    parameter int X_BITS     = 10,
    parameter int Y_BITS     = 9,
    parameter int CH_BITS    = 8,
    parameter int FB_WIDTH   = 640,
    parameter int FB_HEIGHT  = 480,
    parameter int ADDR_BITS  = 19,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          data_avail_i,
    input  logic [X_BITS-1:0]             x_i,
    input  logic [Y_BITS-1:0]             y_i,
    input  logic [CH_BITS-1:0]            r_i,
    input  logic [CH_BITS-1:0]            g_i,
    input  logic [CH_BITS-1:0]            b_i,
    output logic                          sram_req_o,
    output logic [ADDR_BITS-1:0]          sram_addr_o,
    output logic [3*CH_BITS-1:0]          sram_wdata_o,
    input  logic                          sram_ack_i,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
    output logic                          overflow_o,
`ifdef GPU_FB_DROP_CNT_EN
    output logic [15:0]                   drop_count_o,
`endif
    output logic                          idle_o
);
    localparam int DW = 3*CH_BITS;
    localparam int EW = ADDR_BITS + DW;
    localparam logic [X_BITS:0] X_LIM = (X_BITS+1)'(FB_WIDTH);
    localparam logic [Y_BITS:0] Y_LIM = (Y_BITS+1)'(FB_HEIGHT);

    typedef enum logic {S_IDLE, S_REQ} state_t;

    state_t                 state, state_nxt;
    logic                   in_range, pixel_ok;
    logic                   push, pop, full, empty, ovf_drop;
    logic [ADDR_BITS-1:0]   pix_addr;
    logic [EW-1:0]          fifo_dout;

    assign in_range = ({1'b0, x_i} < X_LIM) && ({1'b0, y_i} < Y_LIM);
    assign pixel_ok = data_avail_i && in_range;
    assign pix_addr = ADDR_BITS'(y_i) * ADDR_BITS'(FB_WIDTH) + ADDR_BITS'(x_i);
    // A full FIFO still accepts a pixel when the head leaves on the same edge.
    assign push     = pixel_ok && (!full || pop);
    assign ovf_drop = pixel_ok && full && !pop;

    gpu_fb_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   ({pix_addr, r_i, g_i, b_i}),
        .dout  (fifo_dout),
        .count (fifo_count_o),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            S_IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (sram_ack_i) begin
                    if (!empty) pop = 1'b1;
                    else        state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            sram_req_o   <= 1'b0;
            sram_addr_o  <= '0;
            sram_wdata_o <= '0;
            overflow_o   <= 1'b0;
        end else begin
            state      <= state_nxt;
            sram_req_o <= (state_nxt == S_REQ);
            if (pop) begin
                {sram_addr_o, sram_wdata_o} <= fifo_dout;
            end
            if (ovf_drop) overflow_o <= 1'b1;
        end
    end

    assign idle_o = empty && !sram_req_o;

`ifdef GPU_FB_DROP_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_count_o <= '0;
        end else if ((data_avail_i && !in_range) || ovf_drop) begin
            if (drop_count_o != 16'hFFFF) drop_count_o <= drop_count_o + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_gpu_fb_writer.sv
// Directed bench for gpu_fb_writer: reset, single write, clipping, fill/overflow, drain order, reset mid-write.
module tb_gpu_fb_writer;
    logic        tb_clk = 1'b0;
    logic        rst = 1'b1;
    logic        data_avail_i = 1'b0;
    logic [9:0]  x_i = '0;
    logic [8:0]  y_i = '0;
    logic [7:0]  r_i = '0, g_i = '0, b_i = '0;
    logic        sram_req_o;
    logic [18:0] sram_addr_o;
    logic [23:0] sram_wdata_o;
    logic        sram_ack_i = 1'b0;
    logic [4:0]  fifo_count_o;
    logic        overflow_o;
    logic        idle_o;
`ifdef GPU_FB_DROP_CNT_EN
    logic [15:0] drop_count_o;
`endif

    int checks = 0;
    int errors = 0;
    logic [42:0] exp_q[$];

    always #5 tb_clk = ~tb_clk;

    gpu_fb_writer dut (
        .clk          (tb_clk),
        .rst          (rst),
        .data_avail_i (data_avail_i),
        .x_i          (x_i),
        .y_i          (y_i),
        .r_i          (r_i),
        .g_i          (g_i),
        .b_i          (b_i),
        .sram_req_o   (sram_req_o),
        .sram_addr_o  (sram_addr_o),
        .sram_wdata_o (sram_wdata_o),
        .sram_ack_i   (sram_ack_i),
        .fifo_count_o (fifo_count_o),
        .overflow_o   (overflow_o),
`ifdef GPU_FB_DROP_CNT_EN
        .drop_count_o (drop_count_o),
`endif
        .idle_o       (idle_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge tb_clk);
        #1;
    endtask

    task automatic set_pix(input int x, input int y, input logic [7:0] r, input logic [7:0] g,
                           input logic [7:0] b);
        data_avail_i = 1'b1;
        x_i = 10'(x);
        y_i = 9'(y);
        r_i = r;
        g_i = g;
        b_i = b;
    endtask

    initial begin
        logic [42:0] e;

        // Reset state
        tick(); tick();
        rst = 1'b0;
        chk("rst_req", 32'(sram_req_o), 0);
        chk("rst_addr", 32'(sram_addr_o), 0);
        chk("rst_wdata", 32'(sram_wdata_o), 0);
        chk("rst_count", 32'(fifo_count_o), 0);
        chk("rst_ovf", 32'(overflow_o), 0);
        chk("rst_idle", 32'(idle_o), 1);

        // Single pixel (5,2)
        set_pix(5, 2, 8'h11, 8'h22, 8'h33);
        tick();
        data_avail_i = 1'b0;
        chk("single_req_n", 32'(sram_req_o), 0);
        chk("single_cnt_n", 32'(fifo_count_o), 1);
        chk("single_idle_n", 32'(idle_o), 0);
        tick();
        chk("single_req", 32'(sram_req_o), 1);
        chk("single_addr", 32'(sram_addr_o), 1285);
        chk("single_wdata", 32'(sram_wdata_o), 32'h112233);
        chk("single_cnt", 32'(fifo_count_o), 0);
        tick();
        chk("single_hold", 32'(sram_req_o), 1);
        sram_ack_i = 1'b1;
        tick();
        sram_ack_i = 1'b0;
        chk("single_req_drop", 32'(sram_req_o), 0);
        chk("single_idle", 32'(idle_o), 1);

        // Clipping
        set_pix(640, 0, 8'hAA, 8'hBB, 8'hCC); tick();
        set_pix(0, 480, 8'hAA, 8'hBB, 8'hCC); tick();
        chk("clip_cnt", 32'(fifo_count_o), 0);
        set_pix(639, 479, 8'h01, 8'h02, 8'h03); tick();
        data_avail_i = 1'b0;
        tick();
        chk("clip_req", 32'(sram_req_o), 1);
        chk("clip_addr", 32'(sram_addr_o), 307199);
        chk("clip_wdata", 32'(sram_wdata_o), 32'h010203);
        chk("clip_ovf", 32'(overflow_o), 0);
`ifdef GPU_FB_DROP_CNT_EN
        chk("clip_drops", 32'(drop_count_o), 2);
`endif
        sram_ack_i = 1'b1;
        tick();
        sram_ack_i = 1'b0;
        chk("clip_done", 32'(idle_o), 1);

        // Burst with ack low: fill output register plus FIFO
        for (int i = 0; i < 17; i++) begin
            set_pix(i, 1, 8'(i), 8'(8'hF0 ^ i), 8'(i + 7));
            exp_q.push_back({19'(640 + i), 8'(i), 8'(8'hF0 ^ i), 8'(i + 7)});
            tick();
            if (i == 15) begin
                chk("burst_cnt15", 32'(fifo_count_o), 15);
                chk("burst_ovf15", 32'(overflow_o), 0);
            end
        end
        chk("full_cnt", 32'(fifo_count_o), 16);
        chk("full_ovf", 32'(overflow_o), 0);
        chk("full_head", 32'(sram_addr_o), 640);

        // Full FIFO, pop and push on the same edge
        set_pix(100, 2, 8'h5A, 8'hA5, 8'h3C);
        exp_q.push_back({19'(1380), 8'h5A, 8'hA5, 8'h3C});
        sram_ack_i = 1'b1;
        tick();
        sram_ack_i = 1'b0;
        void'(exp_q.pop_front());
        chk("fullpop_cnt", 32'(fifo_count_o), 16);
        chk("fullpop_ovf", 32'(overflow_o), 0);
        chk("fullpop_addr", 32'(sram_addr_o), 641);

        // Full FIFO, no pop: dropped
        set_pix(200, 3, 8'hEE, 8'hEE, 8'hEE);
        tick();
        data_avail_i = 1'b0;
        chk("ovf_set", 32'(overflow_o), 1);
        chk("ovf_cnt", 32'(fifo_count_o), 16);
`ifdef GPU_FB_DROP_CNT_EN
        chk("ovf_drops", 32'(drop_count_o), 3);
`endif

        // Drain back-to-back in order
        sram_ack_i = 1'b1;
        for (int i = 0; i < 17; i++) begin
            e = exp_q.pop_front();
            chk("drain_req", 32'(sram_req_o), 1);
            chk("drain_addr", 32'(sram_addr_o), 32'(e[42:24]));
            chk("drain_wdata", 32'(sram_wdata_o), 32'(e[23:0]));
            tick();
        end
        sram_ack_i = 1'b0;
        chk("drain_end_req", 32'(sram_req_o), 0);
        chk("drain_end_idle", 32'(idle_o), 1);
        chk("drain_ovf_sticky", 32'(overflow_o), 1);

        // Reset while in REQ with 5 queued
        for (int i = 0; i < 6; i++) begin
            set_pix(i, 10, 8'h10, 8'h20, 8'h30);
            tick();
        end
        data_avail_i = 1'b0;
        chk("mid_cnt", 32'(fifo_count_o), 5);
        chk("mid_req", 32'(sram_req_o), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_req", 32'(sram_req_o), 0);
        chk("mid_rst_cnt", 32'(fifo_count_o), 0);
        chk("mid_rst_idle", 32'(idle_o), 1);
        chk("mid_rst_ovf", 32'(overflow_o), 0);
        sram_ack_i = 1'b1;
        tick();
        sram_ack_i = 1'b0;
        chk("mid_ack_req", 32'(sram_req_o), 0);
        chk("mid_ack_idle", 32'(idle_o), 1);

`ifdef GPU_FB_DROP_CNT_EN
        chk("sat_start", 32'(drop_count_o), 0);
        set_pix(700, 0, 8'h00, 8'h00, 8'h00);
        for (int i = 0; i < 65540; i++) @(posedge tb_clk);
        #1;
        data_avail_i = 1'b0;
        chk("sat_drops", 32'(drop_count_o), 32'hFFFF);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
